// File: rtl/simple_tap_mem_ctrl_pkg.sv
// Shared types and constants for the tap memory controller slice.
package simple_tap_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIN   = 2'd1,
        INTER = 2'd2,
        DRAIN = 2'd3
    } tap_ctrl_state_e;

    localparam int TAP_BANKS  = 6;
    localparam int TAP_ROWS   = 32;
    localparam int TAP_ROW_AW = $clog2(TAP_ROWS);

endpackage

// File: rtl/simple_tap_window_chk.sv
// Modulo-row-count window containment: hit when addr lies in [start, start+len-1], wrapping.
module simple_tap_window_chk
    import simple_tap_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = TAP_ROW_AW
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_start,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_hit
);

    logic [ADDR_W-1:0] w_offset;

    // Natural wrap of the subtraction gives the distance from start modulo the row count.
    assign w_offset = i_addr - i_start;
    assign o_hit    = ({1'b0, w_offset} < i_len);

endmodule

// File: rtl/simple_tap_mem_ctrl.sv
// Read-sweep sequencer and update-write arbiter in front of the banked tap memory.
module simple_tap_mem_ctrl
    import simple_tap_mem_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = TAP_BANKS,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = TAP_ROW_AW,
    parameter int RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        start_inter,
    input  logic [ADDR_W-1:0]           base_row,
    input  logic [ADDR_W:0]             row_count,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_data_vld,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic                        upd_sub,
    input  logic [2:0]                  upd_lane,
    input  logic [ADDR_W-1:0]           upd_addr,
    input  logic [NUM_BANKS*DATA_W-1:0] upd_data,
    output logic [ADDR_W-1:0]           tap_rd_address,
    output logic                        tap_rd_vld,
    output logic [ADDR_W-1:0]           tap_wr_address,
    output logic                        tap_wr_vld,
    output logic [2:0]                  tap_sub_addr,
    output logic                        tap_sub_vld,
    output logic [DATA_W-1:0]           tap_sub_data,
    output logic [NUM_BANKS*DATA_W-1:0] tap_wr_data,
    output logic                        tap_inter,
    output logic                        tap_inter_first
);

    localparam logic [ADDR_W:0]   REM_ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]        LANE_LIMIT  = 3'(NUM_BANKS);
    localparam logic [RD_LAT-1:0] VLD_LOW_MSK = {RD_LAT{1'b1}} >> 1;

    tap_ctrl_state_e          r_state;
    logic [ADDR_W-1:0]        r_rd_ptr;
    logic [ADDR_W:0]          r_remaining;
    logic                     r_rd_vld;
    logic                     r_inter;
    logic                     r_inter_first;
    logic                     r_done;
    logic [RD_LAT-1:0]        r_vld_sr;

    logic                     r_wr_vld;
    logic                     r_sub_vld;
    logic [ADDR_W-1:0]        r_wr_addr;
    logic [2:0]               r_sub_addr;
    logic [DATA_W-1:0]        r_sub_data;
    logic [NUM_BANKS*DATA_W-1:0] r_wr_data;

    logic w_hit;
    logic w_upd_ready;
    logic w_upd_fire;
    logic w_last;
    logic w_inflight_next;
    logic w_lane_ok;

    simple_tap_window_chk #(
        .ADDR_W (ADDR_W)
    ) u_window (
        .i_addr  (upd_addr),
        .i_start (r_rd_ptr),
        .i_len   (r_remaining),
        .o_hit   (w_hit)
    );

    // The row presented this cycle stays in the window: a write accepted now lands after it is read.
    assign w_upd_ready     = !((r_state == LIN && w_hit) || r_state == INTER);
    assign w_upd_fire      = upd_valid && w_upd_ready;
    assign w_lane_ok       = (upd_lane < LANE_LIMIT);
    assign w_last          = (r_remaining == REM_ONE);
    assign w_inflight_next = |(r_vld_sr & VLD_LOW_MSK);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rd_ptr      <= '0;
            r_remaining   <= '0;
            r_rd_vld      <= 1'b0;
            r_inter       <= 1'b0;
            r_inter_first <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (row_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_remaining <= row_count;
                            r_rd_vld    <= 1'b1;
                            if (start_inter) begin
                                r_state       <= INTER;
                                r_rd_ptr      <= '0;
                                r_inter       <= 1'b1;
                                r_inter_first <= 1'b1;
                            end else begin
                                r_state  <= LIN;
                                r_rd_ptr <= base_row;
                            end
                        end
                    end
                end
                LIN: begin
                    r_remaining <= r_remaining - REM_ONE;
                    if (w_last) begin
                        r_state  <= DRAIN;
                        r_rd_vld <= 1'b0;
                        r_rd_ptr <= '0;
                    end else begin
                        r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    end
                end
                INTER: begin
                    r_inter_first <= 1'b0;
                    r_remaining   <= r_remaining - REM_ONE;
                    if (w_last) begin
                        r_state  <= DRAIN;
                        r_rd_vld <= 1'b0;
                        r_inter  <= 1'b0;
                    end
                end
                DRAIN: begin
                    // done is shown while still busy; the following edge returns to IDLE.
                    if (r_done) begin
                        r_state <= IDLE;
                    end else if (!w_inflight_next) begin
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_rd_lat
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (reset) r_vld_sr[gi] <= 1'b0;
                else       r_vld_sr[gi] <= r_rd_vld;
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (reset) r_vld_sr[gi] <= 1'b0;
                else       r_vld_sr[gi] <= r_vld_sr[gi-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_vld   <= 1'b0;
            r_sub_vld  <= 1'b0;
            r_wr_addr  <= '0;
            r_sub_addr <= '0;
            r_sub_data <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_vld  <= w_upd_fire && !upd_sub;
            // Out-of-range lanes are acknowledged but never reach the memory.
            r_sub_vld <= w_upd_fire && upd_sub && w_lane_ok;
            if (w_upd_fire) begin
                r_wr_addr  <= upd_addr;
                r_wr_data  <= upd_data;
                r_sub_addr <= upd_lane;
                r_sub_data <= upd_data[DATA_W-1:0];
            end
        end
    end

    assign busy            = (r_state != IDLE);
    assign done            = r_done;
    assign rd_data_vld     = r_vld_sr[RD_LAT-1];
    assign upd_ready       = w_upd_ready;
    assign tap_rd_address  = r_rd_ptr;
    assign tap_rd_vld      = r_rd_vld;
    assign tap_inter       = r_inter;
    assign tap_inter_first = r_inter_first;
    assign tap_wr_address  = r_wr_addr;
    assign tap_wr_vld      = r_wr_vld;
    assign tap_wr_data     = r_wr_data;
    assign tap_sub_addr    = r_sub_addr;
    assign tap_sub_vld     = r_sub_vld;
    assign tap_sub_data    = r_sub_data;

endmodule

// File: tb/tb_simple_tap_mem_ctrl.sv
// Directed bench for simple_tap_mem_ctrl: sweeps, hazard guard, sub-lane writes and reset abort.
module tb_simple_tap_mem_ctrl;

    localparam int NB = 6;
    localparam int DW = 32;
    localparam int AW = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             start_inter;
    logic [AW-1:0]    base_row;
    logic [AW:0]      row_count;
    logic             busy;
    logic             done;
    logic             rd_data_vld;
    logic             upd_valid;
    logic             upd_ready;
    logic             upd_sub;
    logic [2:0]       upd_lane;
    logic [AW-1:0]    upd_addr;
    logic [NB*DW-1:0] upd_data;
    logic [AW-1:0]    tap_rd_address;
    logic             tap_rd_vld;
    logic [AW-1:0]    tap_wr_address;
    logic             tap_wr_vld;
    logic [2:0]       tap_sub_addr;
    logic             tap_sub_vld;
    logic [DW-1:0]    tap_sub_data;
    logic [NB*DW-1:0] tap_wr_data;
    logic             tap_inter;
    logic             tap_inter_first;

    int n_asserts = 0;
    int n_fail    = 0;

    simple_tap_mem_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .start_inter     (start_inter),
        .base_row        (base_row),
        .row_count       (row_count),
        .busy            (busy),
        .done            (done),
        .rd_data_vld     (rd_data_vld),
        .upd_valid       (upd_valid),
        .upd_ready       (upd_ready),
        .upd_sub         (upd_sub),
        .upd_lane        (upd_lane),
        .upd_addr        (upd_addr),
        .upd_data        (upd_data),
        .tap_rd_address  (tap_rd_address),
        .tap_rd_vld      (tap_rd_vld),
        .tap_wr_address  (tap_wr_address),
        .tap_wr_vld      (tap_wr_vld),
        .tap_sub_addr    (tap_sub_addr),
        .tap_sub_vld     (tap_sub_vld),
        .tap_sub_data    (tap_sub_data),
        .tap_wr_data     (tap_wr_data),
        .tap_inter       (tap_inter),
        .tap_inter_first (tap_inter_first)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_busy"},        192'(busy), 192'(0));
        chk({pfx, "_done"},        192'(done), 192'(0));
        chk({pfx, "_rd_data_vld"}, 192'(rd_data_vld), 192'(0));
        chk({pfx, "_upd_ready"},   192'(upd_ready), 192'(1));
        chk({pfx, "_rd_addr"},     192'(tap_rd_address), 192'(0));
        chk({pfx, "_rd_vld"},      192'(tap_rd_vld), 192'(0));
        chk({pfx, "_wr_addr"},     192'(tap_wr_address), 192'(0));
        chk({pfx, "_wr_vld"},      192'(tap_wr_vld), 192'(0));
        chk({pfx, "_sub_addr"},    192'(tap_sub_addr), 192'(0));
        chk({pfx, "_sub_vld"},     192'(tap_sub_vld), 192'(0));
        chk({pfx, "_sub_data"},    192'(tap_sub_data), 192'(0));
        chk({pfx, "_wr_data"},     tap_wr_data, 192'(0));
        chk({pfx, "_inter"},       192'(tap_inter), 192'(0));
        chk({pfx, "_inter_first"}, 192'(tap_inter_first), 192'(0));
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 20 && busy; k++) step();
        chk({tag, "_idle_timeout"}, 192'(busy), 192'(0));
    endtask

    initial begin
        logic [AW-1:0]    ea;
        logic [NB*DW-1:0] row_pat;
        int               busy_cnt;
        int               done_cnt;

        reset = 1'b1; start = 1'b0; start_inter = 1'b0; base_row = '0; row_count = '0;
        upd_valid = 1'b0; upd_sub = 1'b0; upd_lane = '0; upd_addr = '0; upd_data = '0;
        repeat (3) step();
        chk_quiet("reset");
        $display("reset: outputs checked");
        reset = 1'b0;
        step();

        // Linear sweep base 3, count 4
        start = 1'b1; base_row = 5'd3; row_count = 6'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ea = 5'(3 + i);
            chk("lin_rd_addr", 192'(tap_rd_address), 192'(ea));
            chk("lin_rd_vld", 192'(tap_rd_vld), 192'(1));
            chk("lin_rd_data_vld", 192'(rd_data_vld), 192'(i > 0));
            chk("lin_busy", 192'(busy), 192'(1));
            $display("linear: beat %0d address %0d", i, tap_rd_address);
            step();
        end
        chk("lin_drain_rd_vld", 192'(tap_rd_vld), 192'(0));
        chk("lin_drain_data_vld", 192'(rd_data_vld), 192'(1));
        chk("lin_drain_done", 192'(done), 192'(0));
        step();
        chk("lin_done", 192'(done), 192'(1));
        chk("lin_done_data_vld", 192'(rd_data_vld), 192'(0));
        step();
        chk("lin_done_pulse", 192'(done), 192'(0));
        chk("lin_idle", 192'(busy), 192'(0));

        // Wrapping linear sweep base 30, count 4
        start = 1'b1; base_row = 5'd30; row_count = 6'd4;
        step();
        start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            ea = 5'(30 + i);
            chk("wrap_rd_addr", 192'(tap_rd_address), 192'(ea));
            if (busy) busy_cnt++;
            $display("wrap: beat %0d address %0d", i, tap_rd_address);
            step();
        end
        for (int k = 0; k < 10 && busy; k++) begin
            busy_cnt++;
            step();
        end
        chk("wrap_busy_cycles", 192'(busy_cnt), 192'(6));

        // Interleaved sweep of 12 beats
        start = 1'b1; start_inter = 1'b1; base_row = 5'd9; row_count = 6'd12;
        step();
        start = 1'b0; start_inter = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("inter_flag", 192'(tap_inter), 192'(1));
            chk("inter_first", 192'(tap_inter_first), 192'(i == 0));
            chk("inter_rd_vld", 192'(tap_rd_vld), 192'(1));
            chk("inter_rd_addr", 192'(tap_rd_address), 192'(0));
            chk("inter_upd_ready", 192'(upd_ready), 192'(0));
            step();
        end
        $display("interleave: 12 beats issued");
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) done_cnt++;
            step();
        end
        chk("inter_done_count", 192'(done_cnt), 192'(1));
        chk("inter_end_flag", 192'(tap_inter), 192'(0));
        chk("inter_end_busy", 192'(busy), 192'(0));

        // Hazard: linear sweep base 10, count 8, update to row 14
        row_pat = {32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                   32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        start = 1'b1; base_row = 5'd10; row_count = 6'd8;
        step();
        start = 1'b0;
        chk("haz_rd_addr_first", 192'(tap_rd_address), 192'(10));
        step();
        chk("haz_rd_addr_second", 192'(tap_rd_address), 192'(11));
        upd_valid = 1'b1; upd_sub = 1'b0; upd_addr = 5'd14; upd_data = row_pat;
        #1;
        chk("haz_block_11", 192'(upd_ready), 192'(0));
        for (int p = 12; p <= 14; p++) begin
            step();
            chk("haz_rd_addr", 192'(tap_rd_address), 192'(p));
            chk("haz_block", 192'(upd_ready), 192'(0));
            chk("haz_no_wr", 192'(tap_wr_vld), 192'(0));
        end
        step();
        chk("haz_rd_addr_15", 192'(tap_rd_address), 192'(15));
        chk("haz_release", 192'(upd_ready), 192'(1));
        step();
        chk("haz_wr_vld", 192'(tap_wr_vld), 192'(1));
        chk("haz_wr_addr", 192'(tap_wr_address), 192'(14));
        chk("haz_wr_data", tap_wr_data, row_pat);
        chk("haz_sub_vld", 192'(tap_sub_vld), 192'(0));
        $display("hazard: row 14 written at read pointer %0d", tap_rd_address);
        upd_addr = 5'd2;
        #1;
        chk("haz_outside_ready", 192'(upd_ready), 192'(1));
        step();
        chk("haz_outside_wr_vld", 192'(tap_wr_vld), 192'(1));
        chk("haz_outside_wr_addr", 192'(tap_wr_address), 192'(2));
        upd_valid = 1'b0;
        step();
        chk("haz_wr_vld_clear", 192'(tap_wr_vld), 192'(0));
        wait_idle("haz");

        // Sub-lane write, lane 4
        upd_valid = 1'b1; upd_sub = 1'b1; upd_lane = 3'd4; upd_addr = 5'd7;
        upd_data = {160'h0, 32'hDEAD_BEEF};
        #1;
        chk("sub_ready", 192'(upd_ready), 192'(1));
        step();
        upd_valid = 1'b0;
        chk("sub_vld", 192'(tap_sub_vld), 192'(1));
        chk("sub_addr", 192'(tap_sub_addr), 192'(4));
        chk("sub_data", 192'(tap_sub_data), 192'(32'hDEAD_BEEF));
        chk("sub_wr_vld", 192'(tap_wr_vld), 192'(0));
        chk("sub_wr_addr", 192'(tap_wr_address), 192'(7));
        $display("sub write: lane %0d data %08h", tap_sub_addr, tap_sub_data);
        // Lane 6 is out of range: accepted, nothing issued
        upd_valid = 1'b1; upd_lane = 3'd6;
        #1;
        chk("lane6_ready", 192'(upd_ready), 192'(1));
        step();
        upd_valid = 1'b0;
        chk("lane6_sub_vld", 192'(tap_sub_vld), 192'(0));
        chk("lane6_wr_vld", 192'(tap_wr_vld), 192'(0));
        upd_sub = 1'b0;

        // Zero-length start
        start = 1'b1; row_count = 6'd0;
        step();
        start = 1'b0;
        chk("zero_busy", 192'(busy), 192'(0));
        chk("zero_done", 192'(done), 192'(1));
        chk("zero_rd_vld", 192'(tap_rd_vld), 192'(0));
        step();
        chk("zero_done_clear", 192'(done), 192'(0));

        // Reset during the 2nd beat of a 6-beat sweep
        start = 1'b1; base_row = 5'd0; row_count = 6'd6;
        step();
        start = 1'b0;
        step();
        chk("rst_beat2_addr", 192'(tap_rd_address), 192'(1));
        reset = 1'b1;
        step();
        chk_quiet("midrst");
        reset = 1'b0;
        start = 1'b1; base_row = 5'd8; row_count = 6'd1;
        step();
        start = 1'b0;
        chk("post_rst_busy", 192'(busy), 192'(1));
        chk("post_rst_rd_addr", 192'(tap_rd_address), 192'(8));
        chk("post_rst_rd_vld", 192'(tap_rd_vld), 192'(1));
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) done_cnt++;
            step();
        end
        chk("post_rst_done_count", 192'(done_cnt), 192'(1));
        $display("reset abort: new single-row sweep completed");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_tap_mem_ctrl.md
Name: simple_tap_mem_ctrl

Overview:
- Sequencer and arbiter in front of the 6-bank tap memory (6 x 32-bit lanes, 32 rows).
- Drives the tap interface fields: rd_address, rd_vld, wr_address, wr_vld, sub_addr, sub_vld, sub_data, inter and inter_first.
- Runs two kinds of compute read sweep: linear (row by row) and interleaved (the tap block's internal rotating counters make the addresses).
- Shares the write port with a weight-update requester through a valid/ready handshake, with a read/write hazard guard.

Parameters:
- NUM_BANKS, 6, number of 32-bit lanes per row (also the interleave period)
- DATA_W, 32, width of one lane
- ADDR_W, 5, row address width
- RD_LAT, 1, memory read latency in cycles

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle sweep request; accepted only in IDLE
- start_inter  in  1  sampled with start; 1 selects an interleaved sweep
- base_row  in  ADDR_W  first row of a linear sweep
- row_count  in  ADDR_W+1  rows (linear) or beats (interleaved); 1..32
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse after the last read data is returned
- rd_data_vld  out  1  tap_int_rd_data is valid this cycle
- upd_valid  in  1  update write request
- upd_ready  out  1  update write accepted this cycle
- upd_sub  in  1  1 = single-lane write, 0 = full-row write
- upd_lane  in  3  lane index for a single-lane write (0..5)
- upd_addr  in  ADDR_W  target row
- upd_data  in  NUM_BANKS*DATA_W  full-row data; lane data is taken from bits [31:0]
- tap_rd_address  out  ADDR_W  to tap rd_address
- tap_rd_vld  out  1  to tap rd_vld
- tap_wr_address  out  ADDR_W  to tap wr_address
- tap_wr_vld  out  1  to tap wr_vld
- tap_sub_addr  out  3  to tap sub_addr
- tap_sub_vld  out  1  to tap sub_vld
- tap_sub_data  out  DATA_W  to tap sub_data
- tap_wr_data  out  NUM_BANKS*DATA_W  to tap_int_wr_data
- tap_inter  out  1  to tap inter
- tap_inter_first  out  1  to tap inter_first

Behaviour:
- Reset: clk and reset are as stated in Ports (clock clk; reset synchronous, active-high). Every output is 0 at reset, except upd_ready, which is 1. The FSM enters IDLE.
- FSM states: IDLE, LIN, INTER, DRAIN.
- IDLE:
  - start && !start_inter && row_count!=0 -> LIN; latch base_row into rd_ptr and row_count into remaining.
  - start && start_inter && row_count!=0 -> INTER; latch remaining.
  - start with row_count==0 -> no state change; done pulses on the next cycle.
- LIN:
  - Each cycle: tap_rd_vld=1, tap_rd_address=rd_ptr, rd_ptr+1 (modulo 32), remaining-1.
  - When remaining reaches 1, the last read issues and the FSM goes to DRAIN.
- INTER:
  - tap_inter=1 and tap_rd_vld=1 on every beat.
  - tap_inter_first=1 on the first beat only; it resets the tap block's counters, and that beat reads tap_rd_address, which is 0.
  - Later beats hold tap_rd_address=0; the datapath overrides it.
  - After count beats -> DRAIN.
- DRAIN:
  - Wait RD_LAT cycles. rd_data_vld is tap_rd_vld delayed by RD_LAT via a shift register.
  - When no read is in flight: done=1 for one cycle -> IDLE.
  - With RD_LAT=1, done is asserted in the cycle after the final rd_data_vld.
- busy = (state != IDLE).
- Start handling: start while busy is ignored, not queued.
- Update write arbitration:
  - Writes use the write port independently of reads.
  - Hazard: during LIN, upd_ready=0 if upd_addr lies within the not-yet-read window [rd_ptr, rd_ptr+remaining-1], with the window computed modulo 32.
  - During INTER, upd_ready=0 for every address; the interleave pattern covers rows inter_count_1..+5.
  - In all other cases upd_ready=1.
- Write timing:
  - On upd_valid && upd_ready, the write is registered and issued the next cycle (1-cycle write latency).
  - tap_wr_address=upd_addr; tap_wr_data=upd_data.
  - upd_sub=1: tap_sub_vld=1, tap_sub_addr=upd_lane, tap_sub_data=upd_data[31:0], tap_wr_vld=0.
  - upd_sub=0: tap_wr_vld=1, tap_sub_vld=0.
- upd_lane > 5 with upd_sub=1: the request is accepted and dropped; no sub_vld or wr_vld is issued.
- Simultaneous start and update in IDLE: the update is accepted (window not yet active). The update's write lands the cycle after the first read issue, so a same-row first read returns the old data.
- Reset mid-sweep: the sweep is aborted, in-flight rd_data_vld is cleared, and done is not pulsed.

Decomposition:
- Shared package types.v gets:
  - tap_ctrl_state_e enumeration (IDLE, LIN, INTER, DRAIN)
  - TAP_BANKS=6 constant
  - TAP_ROWS=32 constant
- Sub-module simple_tap_window_chk: modulo-32 window containment check (addr, start, len) -> hit; combinational.

Test Plan:
- Linear sweep: base_row=3, row_count=4 -> tap_rd_address 3,4,5,6 on consecutive cycles; rd_data_vld four cycles, one cycle later; done one cycle after the last rd_data_vld.
- Wrap: base_row=30, row_count=4 -> addresses 30,31,0,1; busy high 6 cycles total.
- Interleaved: start_inter=1, row_count=12 -> tap_inter high 12 cycles; tap_inter_first only on cycle 1; done once after drain.
- Hazard: linear sweep base 10, count 8; upd_addr=14 at the 2nd read -> upd_ready=0 until rd_ptr>14. upd_addr=2 -> upd_ready=1, with wr_vld the next cycle.
- Sub write: upd_sub=1, upd_lane=4, upd_data[31:0]=0xDEADBEEF, addr 7 -> tap_sub_vld=1, tap_sub_addr=4, tap_sub_data=0xDEADBEEF, tap_wr_vld=0. Lane 6 -> nothing issued.
- Reset at the 2nd beat of a 6-beat sweep -> all outputs 0, upd_ready=1, no done; a new start is accepted the cycle after reset deasserts.
